// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite ROM arbiter: shadow config record
// and the per-pixel tag that travels beside the ROM/LUT data pipeline.
package sprite_pkg;

    localparam int PIPE_LAT = 4;
    localparam int HCOUNT_W = 11;
    localparam int VCOUNT_W = 10;
    localparam int ID_W     = 3;

    typedef struct packed {
        logic [HCOUNT_W-1:0] x;
        logic [VCOUNT_W-1:0] y;
        logic                en;
        logic                frame;
    } sprite_cfg_t;

    typedef struct packed {
        logic            hit;
        logic [ID_W-1:0] id;
        logic [7:0]      index;
    } pixel_tag_t;

endpackage

// File: rtl/sprite_hit_decode.sv
// Combinational box test of the current pixel against every shadow sprite,
// with a lowest-index-wins priority encoder and a multi-hit (overlap) flag.
module sprite_hit_decode
    import sprite_pkg::*;
#(
    parameter int NUM_SPRITES = 4,
    parameter int WIDTH       = 30,
    parameter int HEIGHT      = 45
) (
    input  logic [HCOUNT_W-1:0]    hcount,
    input  logic [VCOUNT_W-1:0]    vcount,
    input  sprite_cfg_t            cfg [NUM_SPRITES],
    output logic [NUM_SPRITES-1:0] hit_vec,
    output logic [ID_W-1:0]        win_id,
    output logic                   overlap
);

    logic [HCOUNT_W:0] x_end;
    logic [VCOUNT_W:0] y_end;

    // Right/bottom edges are one bit wider so a sprite near the screen edge cannot wrap.
    always_comb begin
        hit_vec = '0;
        x_end   = '0;
        y_end   = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            x_end = {1'b0, cfg[i].x} + (HCOUNT_W+1)'(WIDTH);
            y_end = {1'b0, cfg[i].y} + (VCOUNT_W+1)'(HEIGHT);
            hit_vec[i] = cfg[i].en
                      && (hcount >= cfg[i].x) && ({1'b0, hcount} < x_end)
                      && (vcount >= cfg[i].y) && ({1'b0, vcount} < y_end);
        end
    end

    always_comb begin
        win_id = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hit_vec[i]) win_id = ID_W'(i);
        end
    end

    // Clearing the lowest set bit leaves something only when two or more hit.
    assign overlap = |(hit_vec & (hit_vec - NUM_SPRITES'(1)));

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one sprite ROM and one R/G/B lookup set between NUM_SPRITES sprites.
// Define SPRITE_TRANSPARENT_KEY_EN to drop pixels whose colour index equals KEY_INDEX.
module sprite_rom_arbiter
    import sprite_pkg::*;
#(
    parameter int         NUM_SPRITES = 4,
    parameter int         WIDTH       = 30,
    parameter int         HEIGHT      = 45,
    parameter int         ADDR_W      = 20,
    parameter logic [7:0] KEY_INDEX   = 8'h00
) (
    input  logic                            pixel_clk,
    input  logic                            reset_n,
    input  logic [HCOUNT_W-1:0]             hcount,
    input  logic [VCOUNT_W-1:0]             vcount,
    input  logic                            frame_start,
    input  logic [HCOUNT_W*NUM_SPRITES-1:0] sprite_x,
    input  logic [VCOUNT_W*NUM_SPRITES-1:0] sprite_y,
    input  logic [NUM_SPRITES-1:0]          sprite_en,
    input  logic [NUM_SPRITES-1:0]          sprite_frame,
    output logic [ADDR_W-1:0]               rom_addr,
    input  logic [7:0]                      rom_data,
    output logic [7:0]                      lut_addr,
    input  logic [7:0]                      red_mapped,
    input  logic [7:0]                      green_mapped,
    input  logic [7:0]                      blue_mapped,
    output logic [23:0]                     pixel,
    output logic                            pixel_hit,
    output logic [ID_W-1:0]                 pixel_id,
    output logic                            overlap
);

`ifdef SPRITE_TRANSPARENT_KEY_EN
    localparam bit KEY_EN = 1'b1;
`else
    localparam bit KEY_EN = 1'b0;
`endif

    sprite_cfg_t            shadow [NUM_SPRITES];
    sprite_cfg_t            win_cfg;
    logic [NUM_SPRITES-1:0] hit_vec;
    logic [ID_W-1:0]        win_id;
    logic                   any_hit;
    logic                   overlap_now;
    logic [HCOUNT_W-1:0]    dx;
    logic [VCOUNT_W-1:0]    dy;
    logic [ADDR_W-1:0]      addr_next;
    pixel_tag_t             tag0, tag1, tag2, tag3, tag2_in;
    logic                   key_miss;
    logic                   pixel_ok;

    // Shadow set only changes on frame_start, so a frame is drawn from one consistent config.
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_SPRITES; i++) shadow[i] <= '0;
        end else if (frame_start) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                shadow[i].x     <= sprite_x[i*HCOUNT_W +: HCOUNT_W];
                shadow[i].y     <= sprite_y[i*VCOUNT_W +: VCOUNT_W];
                shadow[i].en    <= sprite_en[i];
                shadow[i].frame <= sprite_frame[i];
            end
        end
    end

    sprite_hit_decode #(
        .NUM_SPRITES(NUM_SPRITES),
        .WIDTH      (WIDTH),
        .HEIGHT     (HEIGHT)
    ) u_decode (
        .hcount (hcount),
        .vcount (vcount),
        .cfg    (shadow),
        .hit_vec(hit_vec),
        .win_id (win_id),
        .overlap(overlap_now)
    );

    assign any_hit = |hit_vec;

    always_comb begin
        win_cfg = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            if (win_id == ID_W'(i)) win_cfg = shadow[i];
        end
    end

    assign dx = hcount - win_cfg.x;
    assign dy = vcount - win_cfg.y;

    always_comb begin
        addr_next = ADDR_W'(dx) + ADDR_W'(dy) * ADDR_W'(WIDTH)
                  + (win_cfg.frame ? ADDR_W'(WIDTH * HEIGHT) : '0);
        if (!any_hit) addr_next = '0;
    end

    always_comb begin
        tag2_in       = tag1;
        tag2_in.index = rom_data;
    end

    assign key_miss = KEY_EN && (tag3.index == KEY_INDEX);
    assign pixel_ok = tag3.hit && !key_miss;

    // S0 address/tag, S2 ROM index, S4 mapped pixel; S1/S3 are the memories' read cycles.
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_addr  <= '0;
            lut_addr  <= '0;
            tag0      <= '0;
            tag1      <= '0;
            tag2      <= '0;
            tag3      <= '0;
            pixel     <= '0;
            pixel_hit <= 1'b0;
            pixel_id  <= '0;
        end else begin
            rom_addr  <= addr_next;
            tag0      <= '{hit: any_hit, id: win_id, index: 8'h00};
            tag1      <= tag0;
            lut_addr  <= rom_data;
            tag2      <= tag2_in;
            tag3      <= tag2;
            pixel     <= pixel_ok ? {red_mapped, green_mapped, blue_mapped} : 24'h0;
            pixel_hit <= pixel_ok;
            pixel_id  <= pixel_ok ? tag3.id : '0;
        end
    end

    // Clear on frame_start takes precedence over a same-cycle overlap.
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            overlap <= 1'b0;
        end else if (frame_start) begin
            overlap <= 1'b0;
        end else if (overlap_now) begin
            overlap <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: table vectors, random scan against a reference
// model, and a mid-scan reset; expected pixels flow through a scoreboard queue.
module tb_sprite_rom_arbiter;

    localparam int         NUM_SPRITES = 4;
    localparam int         WIDTH       = 30;
    localparam int         HEIGHT      = 45;
    localparam int         ADDR_W      = 20;
    localparam int         LAT         = 4;
    localparam logic [7:0] KEY_INDEX   = 8'h00;

`ifdef SPRITE_TRANSPARENT_KEY_EN
    localparam bit KEY_EN = 1'b1;
`else
    localparam bit KEY_EN = 1'b0;
`endif

    logic                     pixel_clk;
    logic                     reset_n;
    logic [10:0]              hcount;
    logic [9:0]               vcount;
    logic                     frame_start;
    logic [11*NUM_SPRITES-1:0] sprite_x;
    logic [10*NUM_SPRITES-1:0] sprite_y;
    logic [NUM_SPRITES-1:0]   sprite_en;
    logic [NUM_SPRITES-1:0]   sprite_frame;
    logic [ADDR_W-1:0]        rom_addr;
    logic [7:0]               rom_data;
    logic [7:0]               lut_addr;
    logic [7:0]               red_mapped, green_mapped, blue_mapped;
    logic [23:0]              pixel;
    logic                     pixel_hit;
    logic [2:0]               pixel_id;
    logic                     overlap;

    sprite_rom_arbiter #(
        .NUM_SPRITES(NUM_SPRITES),
        .WIDTH      (WIDTH),
        .HEIGHT     (HEIGHT),
        .ADDR_W     (ADDR_W),
        .KEY_INDEX  (KEY_INDEX)
    ) dut (
        .pixel_clk   (pixel_clk),
        .reset_n     (reset_n),
        .hcount      (hcount),
        .vcount      (vcount),
        .frame_start (frame_start),
        .sprite_x    (sprite_x),
        .sprite_y    (sprite_y),
        .sprite_en   (sprite_en),
        .sprite_frame(sprite_frame),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .lut_addr    (lut_addr),
        .red_mapped  (red_mapped),
        .green_mapped(green_mapped),
        .blue_mapped (blue_mapped),
        .pixel       (pixel),
        .pixel_hit   (pixel_hit),
        .pixel_id    (pixel_id),
        .overlap     (overlap)
    );

    // ---------------- clock / reset ----------------
    initial pixel_clk = 1'b0;
    always #5 pixel_clk = ~pixel_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- memory models ----------------
    function automatic logic [7:0] rom_f(input logic [ADDR_W-1:0] a);
        return a[7:0] ^ a[15:8] ^ {a[19:16], 4'h0} ^ 8'hA5;
    endfunction

    function automatic logic [23:0] lut_f(input logic [7:0] idx);
        return {idx, ~idx, idx + 8'd7};
    endfunction

    always @(posedge pixel_clk) begin
        rom_data <= rom_f(rom_addr);
        {red_mapped, green_mapped, blue_mapped} <= lut_f(lut_addr);
    end

    // ---------------- scoreboard / model ----------------
    logic [27:0]       exp_q[$];
    logic [ADDR_W:0]   ea_q[$];
    int                n_checks = 0;
    int                n_errors = 0;
    int                m_x [NUM_SPRITES];
    int                m_y [NUM_SPRITES];
    bit                m_en[NUM_SPRITES];
    bit                m_fr[NUM_SPRITES];
    bit                m_ovl;

    typedef struct {
        int h;
        int v;
        bit fs;
        bit hit;
        int id;
        int addr;
    } vec_t;

    vec_t tbl_a [13];
    vec_t tbl_b [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_eval(input int h, input int v, output bit hit,
                                       output int id, output int addr, output int cnt);
        hit = 0; id = 0; addr = 0; cnt = 0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (m_en[i] && h >= m_x[i] && h < m_x[i] + WIDTH &&
                v >= m_y[i] && v < m_y[i] + HEIGHT) begin
                cnt++;
                hit  = 1;
                id   = i;
                addr = ((h - m_x[i]) + (v - m_y[i]) * WIDTH + (m_fr[i] ? WIDTH * HEIGHT : 0))
                       % (1 << ADDR_W);
            end
        end
    endfunction

    task automatic set_sprite(input int i, input int x, input int y, input bit en, input bit fr);
        sprite_x[i*11 +: 11]  = 11'(x);
        sprite_y[i*10 +: 10]  = 10'(y);
        sprite_en[i]          = en;
        sprite_frame[i]       = fr;
    endtask

    // One pixel clock: retire due expectations, drive the next pixel, queue its expectation.
    task automatic cycle(input int h, input int v, input bit fs,
                         input bit e_hit, input int e_id, input int e_addr);
        bit              mh;
        int              mid, maddr, cnt;
        logic [7:0]      idx;
        bit              hit_eff;
        logic [27:0]     px;
        logic [ADDR_W:0] ea;
        @(negedge pixel_clk);
        if (exp_q.size() == LAT + 1) begin
            px = exp_q.pop_front();
            check("pixel", 32'(pixel), 32'(px[27:4]));
            check("pixel_hit", 32'(pixel_hit), 32'(px[3]));
            check("pixel_id", 32'(pixel_id), 32'(px[2:0]));
        end
        if (ea_q.size() == 1) begin
            ea = ea_q.pop_front();
            check("rom_addr", 32'(rom_addr), 32'(ea[ADDR_W-1:0]));
            check("overlap", 32'(overlap), 32'(ea[ADDR_W]));
        end
        hcount      = 11'(h);
        vcount      = 10'(v);
        frame_start = fs;
        model_eval(h, v, mh, mid, maddr, cnt);
        idx     = rom_f(ADDR_W'(e_addr));
        hit_eff = e_hit && !(KEY_EN && idx == KEY_INDEX);
        exp_q.push_back(hit_eff ? {lut_f(idx), 1'b1, 3'(e_id)} : 28'd0);
        m_ovl = fs ? 1'b0 : (m_ovl || cnt >= 2);
        ea_q.push_back({m_ovl, (e_hit ? ADDR_W'(e_addr) : ADDR_W'(0))});
        if (fs) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                m_x[i]  = int'(sprite_x[i*11 +: 11]);
                m_y[i]  = int'(sprite_y[i*10 +: 10]);
                m_en[i] = sprite_en[i];
                m_fr[i] = sprite_frame[i];
            end
        end
    endtask

    task automatic model_cycle(input int h, input int v, input bit fs);
        bit mh;
        int mid, maddr, cnt;
        model_eval(h, v, mh, mid, maddr, cnt);
        cycle(h, v, fs, mh, mid, maddr);
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        frame_start = 1'b0;
        hcount      = '0;
        vcount      = '0;
        repeat (3) @(negedge pixel_clk);
        reset_n = 1'b1;
        exp_q.delete();
        ea_q.delete();
        repeat (LAT + 1) exp_q.push_back('0);
        ea_q.push_back('0);
        for (int i = 0; i < NUM_SPRITES; i++) begin
            m_x[i] = 0; m_y[i] = 0; m_en[i] = 0; m_fr[i] = 0;
        end
        m_ovl = 1'b0;
    endtask

    // ---------------- test ----------------
    initial begin
        //          h     v    fs hit id addr
        tbl_a = '{'{100,  50, 1, 0, 0,    0},
                  '{100,  50, 0, 1, 0,    0},
                  '{131,  50, 0, 0, 0,    0},
                  '{129,  50, 0, 1, 0,   29},
                  '{115,  55, 0, 1, 0,  165},
                  '{100,  94, 0, 1, 0, 1320},
                  '{100,  95, 0, 0, 0,    0},
                  '{ 99,  50, 0, 0, 0,    0},
                  '{205,  62, 0, 1, 1, 1415},
                  '{2040, 400, 0, 1, 3,   0},
                  '{2047, 401, 0, 1, 3,  37},
                  '{  5, 400, 0, 0, 0,    0},
                  '{ 21, 400, 0, 0, 0,    0}};
        tbl_b = '{'{100,  50, 0, 1, 0,    0},
                  '{300, 100, 0, 0, 0,    0},
                  '{300, 100, 1, 0, 0,    0},
                  '{300, 100, 0, 1, 0,  160},
                  '{100,  50, 0, 0, 0,    0},
                  '{319, 124, 0, 1, 0,  899},
                  '{325, 110, 0, 1, 2, 1675},
                  '{300, 100, 1, 1, 0,  160},
                  '{329, 105, 0, 1, 2, 1529},
                  '{320, 140, 0, 1, 2, 2570}};

        reset_n      = 1'b0;
        frame_start  = 1'b0;
        hcount       = '0;
        vcount       = '0;
        sprite_x     = '0;
        sprite_y     = '0;
        sprite_en    = '0;
        sprite_frame = '0;
        do_reset();

        set_sprite(0, 100, 50, 1, 0);
        set_sprite(1, 200, 60, 1, 1);
        set_sprite(2, 0, 0, 0, 0);
        set_sprite(3, 2040, 400, 1, 0);
        foreach (tbl_a[k]) cycle(tbl_a[k].h, tbl_a[k].v, tbl_a[k].fs,
                                 tbl_a[k].hit, tbl_a[k].id, tbl_a[k].addr);

        // New positions staged without frame_start must not show until the next frame.
        set_sprite(0, 290, 95, 1, 0);
        set_sprite(2, 300, 100, 1, 1);
        foreach (tbl_b[k]) cycle(tbl_b[k].h, tbl_b[k].v, tbl_b[k].fs,
                                 tbl_b[k].hit, tbl_b[k].id, tbl_b[k].addr);

        for (int k = 0; k < 400; k++) begin
            int h, v;
            bit fs;
            if ($urandom_range(0, 24) == 0) begin
                for (int i = 0; i < NUM_SPRITES; i++)
                    set_sprite(i, $urandom_range(250, 360), $urandom_range(80, 150),
                               $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
            end
            fs = ($urandom_range(0, 19) == 0);
            h  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 2047) : $urandom_range(240, 400);
            v  = $urandom_range(60, 200);
            model_cycle(h, v, fs);
        end

        // Reset in the middle of a scan with hits in flight.
        set_sprite(0, 100, 50, 1, 0);
        model_cycle(0, 0, 1);
        model_cycle(105, 52, 0);
        model_cycle(106, 52, 0);
        model_cycle(107, 53, 0);
        @(negedge pixel_clk);
        #2 reset_n = 1'b0;
        #1;
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_lut_addr", 32'(lut_addr), 32'd0);
        check("rst_pixel", 32'(pixel), 32'd0);
        check("rst_pixel_hit", 32'(pixel_hit), 32'd0);
        check("rst_pixel_id", 32'(pixel_id), 32'd0);
        check("rst_overlap", 32'(overlap), 32'd0);
        do_reset();
        repeat (4) model_cycle(105, 52, 0);
        model_cycle(105, 52, 1);
        model_cycle(105, 52, 0);
        model_cycle(129, 94, 0);
        model_cycle(130, 94, 0);
        repeat (LAT + 2) model_cycle(0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sprite_rom_arbiter.md
Name: sprite_rom_arbiter

Overview:
- Shares one sprite image ROM and one R/G/B colour-lookup set between NUM_SPRITES on-screen sprite instances, e.g. a bank of bomb-module switches drawn with one on/off image pair.
- Each pixel it picks the covering sprite, issues the ROM address and routes ROM data to the colour lookups.
- Returns the mapped 24-bit pixel with hit/id tags aligned to a fixed latency.
- Per-sprite position, enable and frame are double-buffered and take effect only at frame start, so sprites never tear.

Parameters:
- NUM_SPRITES, 4, number of requesting sprite instances (1..8).
- WIDTH, 30, sprite width in pixels.
- HEIGHT, 45, sprite height in pixels.
- ADDR_W, 20, image ROM address width.
- KEY_INDEX, 8'h00, colour index treated as transparent (optional feature only).

Ports:
- pixel_clk  in  1  pixel clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- hcount  in  11  current horizontal pixel count.
- vcount  in  10  current vertical line count.
- frame_start  in  1  one-cycle pulse at the start of each frame; loads the shadow config.
- sprite_x  in  11*NUM_SPRITES  packed left edges; sprite i at bits [11i+10:11i].
- sprite_y  in  10*NUM_SPRITES  packed top edges.
- sprite_en  in  NUM_SPRITES  per-sprite enable.
- sprite_frame  in  NUM_SPRITES  image select: 0 = off image, 1 = on image.
- rom_addr  out  ADDR_W  address to the shared image ROM (1-cycle synchronous read).
- rom_data  in  8  colour index from the ROM.
- lut_addr  out  8  address to the shared R/G/B lookups (1-cycle synchronous read).
- red_mapped, green_mapped, blue_mapped  in  8 each  lookup outputs.
- pixel  out  24  {R,G,B}; 0 when no sprite.
- pixel_hit  out  1  pixel belongs to a sprite.
- pixel_id  out  3  index of the winning sprite; 0 when no hit.
- overlap  out  1  sticky: two or more sprites covered one pixel this frame.

Behaviour:
- Reset (asynchronous, active-low):
  - All shadow registers clear; every sprite is disabled.
  - rom_addr, lut_addr, pixel, pixel_hit, pixel_id and overlap = 0.
  - Tag pipeline cleared.
  - Reset mid-frame: output is black until the next frame_start loads the config.
- Shadow load:
  - On frame_start, copy sprite_x, sprite_y, sprite_en and sprite_frame into the shadow set.
  - All hit decisions use shadow values only.
  - Pixels already in flight keep the tags they were issued with.
- Hit test, per sprite i:
  - Enabled, hcount >= x_i and hcount < x_i+WIDTH, vcount >= y_i and vcount < y_i+HEIGHT.
  - Compute the sums 1 bit wider (12/11 bits), so a sprite near the screen edge never wraps.
- Arbitration: fixed priority, lowest index wins.
- overlap:
  - Set when two or more sprites hit the same pixel.
  - Cleared on frame_start; if set and clear coincide, clear wins.
- Address:
  - rom_addr = (hcount-x_w) + (vcount-y_w)*WIDTH + frame_w*WIDTH*HEIGHT, truncated to ADDR_W.
  - rom_addr = 0 on a miss.
- Pipeline: hcount/vcount sampled at edge t produce the pixel after edge t+4.
  - S0 (edge t): register rom_addr, hit, id.
  - S1 (t+1): ROM read.
  - S2 (t+2): register lut_addr = rom_data.
  - S3 (t+3): lookup read.
  - S4 (t+4): register pixel.
  - hit/id travel in a 4-stage shift register beside the data.
  - pixel = {R,G,B} when the tag hit = 1, else 0.
- Throughput: one pixel per clock, no stalls. Back-to-back pixels may come from different sprites.
- frame_start in the same cycle as a sprite-covered pixel: that pixel uses the old shadow set; the new set applies from the next cycle.

Optional Feature:
- SPRITE_TRANSPARENT_KEY_EN defined:
  - At S4, a pixel whose stage-2 colour index equals KEY_INDEX is a miss: pixel = 0, pixel_hit = 0, pixel_id = 0.
  - The index tag is carried alongside the pipeline.
  - No fall-through to a lower-priority sprite.
- Undefined: every hit pixel is emitted as mapped, whatever its index.

Decomposition:
- Package sprite_pkg:
  - Constants PIPE_LAT = 4, HCOUNT_W = 11, VCOUNT_W = 10, ID_W = 3.
  - Typedef sprite_cfg_t {x, y, en, frame} and a packed tag typedef {hit, id, index}.
- Sub-module sprite_hit_decode:
  - Combinational per-sprite box test over the shadow array.
  - Outputs: hit vector, priority-encoded winner, overlap flag.
- The top level holds the shadow registers, address arithmetic and tag pipeline.

Test Plan:
- Reset, then frame_start with sprite 0 at (100,50), enabled, frame 0; scan (100,50) → rom_addr = 0 after 1 edge; pixel = LUT(ROM[0]), pixel_hit = 1, pixel_id = 0 exactly 4 edges after sampling. (131,50) → pixel = 0, hit = 0.
- Sprite 1 frame 1 at (200,60); scan (205,62) → rom_addr = 5 + 2*30 + 1350 = 1415.
- Sprites 0 and 2 overlapping at (300,100) → pixel_id = 0, overlap = 1, held until the next frame_start clears it.
- Change sprite_x mid-frame without frame_start → output unchanged; after frame_start the new position applies from the next cycle.
- Sprite at x = 2040 → hits only hcount 2040..2047; no wrap-around hit at hcount 0..21.
- Assert reset_n low mid-scan → all outputs 0 immediately. With SPRITE_TRANSPARENT_KEY_EN and ROM index 0 → pixel_hit = 0.
